// File: rtl/cu_pkg.sv
// Shared encodings for the multicycle control unit: state codes, instruction
// fields, ALU operation codes and datapath mux selects.
package cu_pkg;

    localparam logic [4:0] S_RESET    = 5'd0;
    localparam logic [4:0] S_FETCH    = 5'd1;
    localparam logic [4:0] S_FETCH_LD = 5'd2;
    localparam logic [4:0] S_DECODE   = 5'd3;
    localparam logic [4:0] S_R_EX     = 5'd4;
    localparam logic [4:0] S_WB_R     = 5'd5;
    localparam logic [4:0] S_ADDI_EX  = 5'd6;
    localparam logic [4:0] S_WB_I     = 5'd7;
    localparam logic [4:0] S_MEMADR   = 5'd8;
    localparam logic [4:0] S_LW_RD    = 5'd9;
    localparam logic [4:0] S_WB_L     = 5'd10;
    localparam logic [4:0] S_SW       = 5'd11;
    localparam logic [4:0] S_BEQ      = 5'd12;
    localparam logic [4:0] S_JUMP     = 5'd13;
    localparam logic [4:0] S_HALT     = 5'd14;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BREAK = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;

    localparam logic [2:0] ULA_NOP = 3'b000;
    localparam logic [2:0] ULA_ADD = 3'b001;
    localparam logic [2:0] ULA_SUB = 3'b010;
    localparam logic [2:0] ULA_AND = 3'b011;
    localparam logic [2:0] ULA_CMP = 3'b111;

    localparam logic IORD_PC      = 1'b0;
    localparam logic IORD_ALUOUT  = 1'b1;
    localparam logic WREG_RT      = 1'b0;
    localparam logic WREG_RD      = 1'b1;
    localparam logic WDATA_ALUOUT = 1'b0;
    localparam logic WDATA_MDR    = 1'b1;
    localparam logic ULAA_PC      = 1'b0;
    localparam logic ULAA_A       = 1'b1;

    localparam logic [1:0] ULAB_B      = 2'b00;
    localparam logic [1:0] ULAB_FOUR   = 2'b01;
    localparam logic [1:0] ULAB_IMM    = 2'b10;
    localparam logic [1:0] ULAB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic rtype_supported(input logic [5:0] funct);
        return (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND);
    endfunction

    function automatic logic [2:0] rtype_ula(input logic [5:0] funct);
        case (funct)
            F_SUB:   return ULA_SUB;
            F_AND:   return ULA_AND;
            default: return ULA_ADD;
        endcase
    endfunction

endpackage

// File: rtl/cu_wait_counter.sv
// Dwell counter for memory-read states: restarts on every state change and
// flags the last cycle of a MEM_LAT-cycle read.
module cu_wait_counter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic done
);

    localparam logic [2:0] LAST = 3'(MEM_LAT - 1);

    logic [2:0] count;

    // Saturate so an absorbing state never wraps back onto LAST.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= 3'd0;
        end else if (count != 3'd7) begin
            count <= count + 3'd1;
        end
    end

    assign done = (count == LAST);

endmodule

// File: rtl/control_unit.sv
// Multicycle Moore control FSM for the add/sub/and/addi/lw/sw/beq/j/break
// subset; drives every datapath enable, ALU op and mux select.
module control_unit
    import cu_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       Of,
    input  logic       Eq,
    output logic       PC_w,
    output logic       MEM_w,
    output logic       IR_w,
    output logic       RB_w,
    output logic       AB_w,
    output logic       ALUOUT_w,
    output logic       MDR_w,
    output logic [2:0] ULA_c,
    output logic       M_IORD,
    output logic       M_WREG,
    output logic       M_WDATA,
    output logic       M_ULAA,
    output logic [1:0] M_ULAB,
    output logic [1:0] M_PCSRC,
    output logic       halted,
    output logic       exc_ovf,
    output logic [4:0] state_dbg
);

    logic [4:0] state;
    logic [4:0] state_nxt;
    logic       ovf_set;
    logic       state_change;
    logic       wait_done;

    assign state_change = (state_nxt != state);

    cu_wait_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_wait (
        .clk   (clk),
        .reset (reset),
        .clr   (state_change),
        .done  (wait_done)
    );

    always_comb begin
        state_nxt = state;
        ovf_set   = 1'b0;
        case (state)
            S_RESET:    state_nxt = S_FETCH;
            S_FETCH:    if (wait_done) state_nxt = S_FETCH_LD;
            S_FETCH_LD: state_nxt = S_DECODE;
            S_DECODE: begin
                case (OPCODE)
                    OP_RTYPE:     state_nxt = rtype_supported(FUNCT) ? S_R_EX : S_HALT;
                    OP_ADDI:      state_nxt = S_ADDI_EX;
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_J:         state_nxt = S_JUMP;
                    default:      state_nxt = S_HALT;
                endcase
            end
            S_R_EX: begin
                // and cannot overflow, so only add/sub trap.
                if (Of && (FUNCT == F_ADD || FUNCT == F_SUB)) begin
                    ovf_set   = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_WB_R;
                end
            end
            S_ADDI_EX: begin
                if (Of) begin
                    ovf_set   = 1'b1;
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_WB_I;
                end
            end
            S_MEMADR:   state_nxt = (OPCODE == OP_LW) ? S_LW_RD : S_SW;
            S_LW_RD:    if (wait_done) state_nxt = S_WB_L;
            S_WB_R, S_WB_I, S_WB_L, S_SW, S_BEQ, S_JUMP: state_nxt = S_FETCH;
            S_HALT:     state_nxt = S_HALT;
            default:    state_nxt = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_RESET;
            exc_ovf <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ovf_set) begin
                exc_ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        PC_w     = 1'b0;
        MEM_w    = 1'b0;
        IR_w     = 1'b0;
        RB_w     = 1'b0;
        AB_w     = 1'b0;
        ALUOUT_w = 1'b0;
        MDR_w    = 1'b0;
        ULA_c    = ULA_NOP;
        M_IORD   = IORD_PC;
        M_WREG   = WREG_RT;
        M_WDATA  = WDATA_ALUOUT;
        M_ULAA   = ULAA_PC;
        M_ULAB   = ULAB_B;
        M_PCSRC  = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                M_ULAB = ULAB_FOUR;
                ULA_c  = ULA_ADD;
            end
            S_FETCH_LD: begin
                M_ULAB = ULAB_FOUR;
                ULA_c  = ULA_ADD;
                IR_w   = 1'b1;
                PC_w   = 1'b1;
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                AB_w     = 1'b1;
                M_ULAB   = ULAB_IMM_SH;
                ULA_c    = ULA_ADD;
                ALUOUT_w = 1'b1;
            end
            S_R_EX: begin
                M_ULAA   = ULAA_A;
                M_ULAB   = ULAB_B;
                ULA_c    = rtype_ula(FUNCT);
                ALUOUT_w = 1'b1;
            end
            S_WB_R: begin
                RB_w   = 1'b1;
                M_WREG = WREG_RD;
            end
            S_ADDI_EX, S_MEMADR: begin
                M_ULAA   = ULAA_A;
                M_ULAB   = ULAB_IMM;
                ULA_c    = ULA_ADD;
                ALUOUT_w = 1'b1;
            end
            S_WB_I: RB_w = 1'b1;
            S_LW_RD: begin
                M_IORD = IORD_ALUOUT;
                MDR_w  = wait_done;
            end
            S_WB_L: begin
                RB_w    = 1'b1;
                M_WDATA = WDATA_MDR;
            end
            S_SW: begin
                M_IORD = IORD_ALUOUT;
                MEM_w  = 1'b1;
            end
            S_BEQ: begin
                M_ULAA  = ULAA_A;
                M_ULAB  = ULAB_B;
                ULA_c   = ULA_CMP;
                M_PCSRC = PCSRC_ALUOUT;
                PC_w    = Eq;
            end
            S_JUMP: begin
                PC_w    = 1'b1;
                M_PCSRC = PCSRC_JUMP;
            end
            default: ;
        endcase
    end

    assign halted    = (state == S_HALT);
    assign state_dbg = state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: cycle-by-cycle vector table on a
// MEM_LAT=1 instance, hand sequences on a MEM_LAT=3 instance.
module tb_control_unit;

    localparam logic [4:0] T_RESET = 5'd0,  T_FETCH = 5'd1,  T_FLD = 5'd2,  T_DEC = 5'd3;
    localparam logic [4:0] T_REX = 5'd4,    T_WBR = 5'd5,    T_AEX = 5'd6,  T_WBI = 5'd7;
    localparam logic [4:0] T_MADR = 5'd8,   T_LWRD = 5'd9,   T_WBL = 5'd10, T_SW = 5'd11;
    localparam logic [4:0] T_BEQ = 5'd12,   T_JUMP = 5'd13,  T_HALT = 5'd14;

    localparam logic [5:0] O_R = 6'h00, O_J = 6'h02, O_BEQ = 6'h04, O_ADDI = 6'h08;
    localparam logic [5:0] O_LW = 6'h23, O_SW = 6'h2B, O_BRK = 6'h0D, O_BAD = 6'h3F;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_BAD = 6'h25;

    // {PC,MEM,IR,RB,AB,ALUOUT,MDR}_{ULA_c}_{IORD,WREG,WDATA,ULAA}_{ULAB}_{PCSRC}_{halted,exc_ovf}
    localparam logic [19:0] C_RESET = 20'b0000000_000_0000_00_00_00;
    localparam logic [19:0] C_FETCH = 20'b0000000_001_0000_01_00_00;
    localparam logic [19:0] C_FLD   = 20'b1010000_001_0000_01_00_00;
    localparam logic [19:0] C_DEC   = 20'b0000110_001_0000_11_00_00;
    localparam logic [19:0] C_RADD  = 20'b0000010_001_0001_00_00_00;
    localparam logic [19:0] C_RSUB  = 20'b0000010_010_0001_00_00_00;
    localparam logic [19:0] C_RAND  = 20'b0000010_011_0001_00_00_00;
    localparam logic [19:0] C_WBR   = 20'b0001000_000_0100_00_00_00;
    localparam logic [19:0] C_IMMEX = 20'b0000010_001_0001_10_00_00;
    localparam logic [19:0] C_WBI   = 20'b0001000_000_0000_00_00_00;
    localparam logic [19:0] C_LWRDF = 20'b0000001_000_1000_00_00_00;
    localparam logic [19:0] C_WBL   = 20'b0001000_000_0010_00_00_00;
    localparam logic [19:0] C_SW    = 20'b0100000_000_1000_00_00_00;
    localparam logic [19:0] C_BEQT  = 20'b1000000_111_0001_00_01_00;
    localparam logic [19:0] C_BEQN  = 20'b0000000_111_0001_00_01_00;
    localparam logic [19:0] C_JUMP  = 20'b1000000_000_0000_00_10_00;
    localparam logic [19:0] C_HALT  = 20'b0000000_000_0000_00_00_10;
    localparam logic [19:0] C_HALTE = 20'b0000000_000_0000_00_00_11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [5:0] OPCODE, FUNCT;
    logic       Of, Eq;

    logic       pc_w1, mem_w1, ir_w1, rb_w1, ab_w1, aluout_w1, mdr_w1;
    logic [2:0] ula_c1;
    logic       iord1, wreg1, wdata1, ulaa1;
    logic [1:0] ulab1, pcsrc1;
    logic       halted1, exc1;
    logic [4:0] st1;

    logic       pc_w3, mem_w3, ir_w3, rb_w3, ab_w3, aluout_w3, mdr_w3;
    logic [2:0] ula_c3;
    logic       iord3, wreg3, wdata3, ulaa3;
    logic [1:0] ulab3, pcsrc3;
    logic       halted3, exc3;
    logic [4:0] st3;

    logic [19:0] ctrl1;
    assign ctrl1 = {pc_w1, mem_w1, ir_w1, rb_w1, ab_w1, aluout_w1, mdr_w1, ula_c1,
                    iord1, wreg1, wdata1, ulaa1, ulab1, pcsrc1, halted1, exc1};

    control_unit #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .Of(Of), .Eq(Eq),
        .PC_w(pc_w1), .MEM_w(mem_w1), .IR_w(ir_w1), .RB_w(rb_w1), .AB_w(ab_w1),
        .ALUOUT_w(aluout_w1), .MDR_w(mdr_w1), .ULA_c(ula_c1), .M_IORD(iord1),
        .M_WREG(wreg1), .M_WDATA(wdata1), .M_ULAA(ulaa1), .M_ULAB(ulab1),
        .M_PCSRC(pcsrc1), .halted(halted1), .exc_ovf(exc1), .state_dbg(st1)
    );

    control_unit #(.MEM_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT), .Of(Of), .Eq(Eq),
        .PC_w(pc_w3), .MEM_w(mem_w3), .IR_w(ir_w3), .RB_w(rb_w3), .AB_w(ab_w3),
        .ALUOUT_w(aluout_w3), .MDR_w(mdr_w3), .ULA_c(ula_c3), .M_IORD(iord3),
        .M_WREG(wreg3), .M_WDATA(wdata3), .M_ULAA(ulaa3), .M_ULAB(ulab3),
        .M_PCSRC(pcsrc3), .halted(halted3), .exc_ovf(exc3), .state_dbg(st3)
    );

    typedef struct packed {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        of;
        logic        eq;
        logic [4:0]  st;
        logic [19:0] ctrl;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic row(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                       input logic of, input logic eq, input logic [4:0] st,
                       input logic [19:0] ctrl);
        vec_t v;
        v.rst = rst; v.op = op; v.fn = fn; v.of = of; v.eq = eq; v.st = st; v.ctrl = ctrl;
        vecs.push_back(v);
    endtask

    task automatic head(input logic [5:0] op, input logic [5:0] fn, input logic of, input logic eq);
        row(1'b0, op, fn, of, eq, T_FETCH, C_FETCH);
        row(1'b0, op, fn, of, eq, T_FLD, C_FLD);
        row(1'b0, op, fn, of, eq, T_DEC, C_DEC);
    endtask

    logic [4:0] lw_seq [10];
    int         mdr_cnt;
    int         mdr_at;

    initial begin
        reset = 1'b1; OPCODE = 6'h00; FUNCT = 6'h00; Of = 1'b0; Eq = 1'b0;
        @(posedge clk);

        row(1, 0, 0, 0, 0, T_RESET, C_RESET);
        row(1, 0, 0, 0, 0, T_RESET, C_RESET);
        row(0, 0, 0, 0, 0, T_RESET, C_RESET);
        head(O_R, FN_ADD, 0, 0);  row(0, O_R, FN_ADD, 0, 0, T_REX, C_RADD);  row(0, O_R, FN_ADD, 0, 0, T_WBR, C_WBR);
        head(O_R, FN_SUB, 0, 0);  row(0, O_R, FN_SUB, 0, 0, T_REX, C_RSUB);  row(0, O_R, FN_SUB, 0, 0, T_WBR, C_WBR);
        head(O_R, FN_AND, 1, 0);  row(0, O_R, FN_AND, 1, 0, T_REX, C_RAND);  row(0, O_R, FN_AND, 1, 0, T_WBR, C_WBR);
        head(O_ADDI, 0, 0, 0);    row(0, O_ADDI, 0, 0, 0, T_AEX, C_IMMEX);   row(0, O_ADDI, 0, 0, 0, T_WBI, C_WBI);
        head(O_LW, 0, 0, 0);      row(0, O_LW, 0, 0, 0, T_MADR, C_IMMEX);
        row(0, O_LW, 0, 0, 0, T_LWRD, C_LWRDF);                              row(0, O_LW, 0, 0, 0, T_WBL, C_WBL);
        head(O_SW, 0, 0, 0);      row(0, O_SW, 0, 0, 0, T_MADR, C_IMMEX);    row(0, O_SW, 0, 0, 0, T_SW, C_SW);
        head(O_BEQ, 0, 0, 1);     row(0, O_BEQ, 0, 0, 1, T_BEQ, C_BEQT);
        head(O_BEQ, 0, 0, 0);     row(0, O_BEQ, 0, 0, 0, T_BEQ, C_BEQN);
        head(O_J, 0, 0, 0);       row(0, O_J, 0, 0, 0, T_JUMP, C_JUMP);
        head(O_R, FN_ADD, 1, 0);  row(0, O_R, FN_ADD, 1, 0, T_REX, C_RADD);
        row(0, O_R, FN_ADD, 0, 0, T_HALT, C_HALTE);  row(1, O_R, FN_ADD, 0, 0, T_HALT, C_HALTE);
        row(0, O_R, FN_ADD, 0, 0, T_RESET, C_RESET);
        head(O_ADDI, 0, 1, 0);    row(0, O_ADDI, 0, 1, 0, T_AEX, C_IMMEX);
        row(0, O_ADDI, 0, 0, 0, T_HALT, C_HALTE);    row(0, O_ADDI, 0, 0, 0, T_HALT, C_HALTE);
        row(1, O_ADDI, 0, 0, 0, T_HALT, C_HALTE);    row(0, O_ADDI, 0, 0, 0, T_RESET, C_RESET);
        head(O_BAD, 0, 0, 0);     row(0, O_BAD, 0, 0, 0, T_HALT, C_HALT);
        row(1, O_BAD, 0, 0, 0, T_HALT, C_HALT);      row(0, O_BAD, 0, 0, 0, T_RESET, C_RESET);
        head(O_BRK, 0, 0, 0);     row(0, O_BRK, 0, 0, 0, T_HALT, C_HALT);
        row(1, O_BRK, 0, 0, 0, T_HALT, C_HALT);      row(0, O_BRK, 0, 0, 0, T_RESET, C_RESET);
        head(O_R, FN_BAD, 0, 0);  row(0, O_R, FN_BAD, 0, 0, T_HALT, C_HALT);
        row(1, O_R, FN_BAD, 0, 0, T_HALT, C_HALT);   row(0, O_R, FN_BAD, 0, 0, T_RESET, C_RESET);
        row(0, O_R, FN_SUB, 0, 0, T_FETCH, C_FETCH); row(0, O_R, FN_SUB, 0, 0, T_FLD, C_FLD);
        row(1, O_R, FN_SUB, 0, 0, T_DEC, C_DEC);     row(0, O_R, FN_SUB, 0, 0, T_RESET, C_RESET);
        row(0, O_R, FN_SUB, 0, 0, T_FETCH, C_FETCH);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; OPCODE = vecs[i].op; FUNCT = vecs[i].fn;
            Of = vecs[i].of; Eq = vecs[i].eq;
            #1;
            chk($sformatf("row%0d state", i), 32'(st1), 32'(vecs[i].st));
            chk($sformatf("row%0d ctrl", i), 32'(ctrl1), 32'(vecs[i].ctrl));
        end

        // lw on the MEM_LAT=3 instance: fetch and read each dwell three cycles.
        lw_seq = '{T_FETCH, T_FETCH, T_FETCH, T_FLD, T_DEC, T_MADR, T_LWRD, T_LWRD, T_LWRD, T_WBL};
        @(negedge clk);
        reset = 1'b1; OPCODE = O_LW; FUNCT = 6'h00; Of = 1'b0; Eq = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1 chk("lat3 reset state", 32'(st3), 32'(T_RESET));
        mdr_cnt = 0;
        mdr_at  = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("lat3 lw cycle%0d state", k), 32'(st3), 32'(lw_seq[k]));
            if (mdr_w3) begin
                mdr_cnt++;
                mdr_at = k;
            end
            if (k >= 6 && k <= 8) chk($sformatf("lat3 lw cycle%0d iord", k), 32'(iord3), 32'd1);
            if (k == 9) begin
                chk("lat3 wb_l wdata", 32'(wdata3), 32'd1);
                chk("lat3 wb_l rb_w", 32'(rb_w3), 32'd1);
            end
        end
        chk("lat3 mdr pulses", 32'(mdr_cnt), 32'd1);
        chk("lat3 mdr cycle", 32'(mdr_at), 32'd8);
        @(negedge clk);
        #1 chk("lat3 back to fetch", 32'(st3), 32'(T_FETCH));

        // Abort a load in the middle of its read wait.
        for (int k = 0; k < 7; k++) @(negedge clk);
        #1 chk("lat3 second lw_rd", 32'(st3), 32'(T_LWRD));
        chk("lat3 mdr before done", 32'(mdr_w3), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        #1 chk("lat3 abort state", 32'(st3), 32'(T_RESET));
        chk("lat3 abort mdr", 32'(mdr_w3), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1 chk("lat3 abort refetch", 32'(st3), 32'(T_FETCH));
        chk("lat3 abort mdr after", 32'(mdr_w3), 32'd0);
        chk("lat3 abort rb_w after", 32'(rb_w3), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
